uart_tx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_param_if.sv | 28 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_param.sv | 120 ++++++++++++
 tb/tb_uart_tx_param.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned UART_DIV_115200 = 434;

  // 2'b11 is treated as "no parity" alongside PAR_NONE
  function automatic logic parity_enabled(input logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word handshake and per-frame configuration into the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [1:0]           cfg_parity;
  logic                 cfg_stop2;

  modport master (
    output tx_data,
    output tx_valid,
    output cfg_parity,
    output cfg_stop2,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  cfg_parity,
    input  cfg_stop2,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_DIV_115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Count within the bit period; wrap to zero on the terminal count only
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1 or 2 stops.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = UART_DIV_115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_param_if.slave   tx_if,
  output logic             rs232_tx,
  output logic             bps_start,
  output logic             tx_busy,
  output logic             frame_done
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q;
  logic [1:0]           par_q;
  logic                 stop2_q;
  logic                 line_d, busy_d, done_d;
  logic                 accept, tick, par_bit;

  assign tx_if.tx_ready = (state_q == IDLE) && !rst;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign par_bit        = (par_q == PAR_ODD) ? ~^data_q : ^data_q;
  assign tx_busy        = bps_start;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state_q != IDLE),
    .tick  (tick)
  );

  // Capture word and frame options at accept; they stay fixed for the whole frame
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
    end else if (accept) begin
      data_q  <= tx_if.tx_data;
      par_q   <= tx_if.cfg_parity;
      stop2_q <= tx_if.cfg_stop2;
    end
  end

  // State register plus registered line/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rs232_tx   <= 1'b1;
      bps_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rs232_tx   <= line_d;
      bps_start  <= busy_d;
      frame_done <= done_d;
    end
  end

  // Next-state: advance one frame field per baud tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && idx_q == LAST_IDX)
                 state_d = parity_enabled(par_q) ? PARITY : STOP1;
      PARITY:  if (tick) state_d = STOP1;
      STOP1:   if (tick) state_d = stop2_q ? STOP2 : IDLE;
      STOP2:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the line register changes
  // on the same edge as the state, giving exact CLK_DIV-cycle bit cells
  always_comb begin
    idx_d  = idx_q;
    line_d = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q != IDLE) && (state_d == IDLE);

    if (state_d != DATA) begin
      idx_d = '0;
    end else if (state_q == DATA && tick) begin
      idx_d = idx_q + 1'b1;
    end

    case (state_d)
      IDLE:    line_d = 1'b1;
      START:   line_d = 1'b0;
      DATA:    line_d = data_q[idx_d];
      PARITY:  line_d = par_bit;
      STOP1:   line_d = 1'b1;
      STOP2:   line_d = 1'b1;
      default: line_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench: drivers queue expected frames, per-instance monitors decode the line.
module tb_uart_tx_param;

  localparam int DIV = 4;

  typedef struct {
    logic [15:0] bits;
    int          len;
    bit          abort;
  } frame_t;

  logic clk, rst;
  logic line8, bps8, busy8, done8;
  logic line7, bps7, busy7, done7;

  int n_checks = 0;
  int n_pass   = 0;

  frame_t q8[$];
  frame_t q7[$];

  uart_tx_param_if #(.DATA_BITS(8)) if8 ();
  uart_tx_param_if #(.DATA_BITS(7)) if7 ();

  uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .tx_if(if8),
    .rs232_tx(line8), .bps_start(bps8), .tx_busy(busy8), .frame_done(done8)
  );

  uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(7)) dut7 (
    .clk(clk), .rst(rst), .tx_if(if7),
    .rs232_tx(line7), .bps_start(bps7), .tx_busy(busy7), .frame_done(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // {frame_done, rs232_tx, bps_start, tx_busy, tx_ready}
  function automatic logic [4:0] snap(input int inst);
    if (inst == 0) return {done8, line8, bps8, busy8, if8.tx_ready};
    return {done7, line7, bps7, busy7, if7.tx_ready};
  endfunction

  function automatic frame_t make_frame(input logic [8:0] d, input int nb, input bit pen,
                                        input logic pb, input bit s2, input bit ab);
    frame_t f;
    int k;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < nb; i++) f.bits[1+i] = d[i];
    k = 1 + nb;
    if (pen) begin
      f.bits[k] = pb;
      k++;
    end
    f.len = k + (s2 ? 2 : 1);
    f.abort = ab;
    return f;
  endfunction

  task automatic monitor(input int inst);
    frame_t f;
    logic [4:0] s, act, want;
    bit aborted, first;
    int qs;
    forever begin
      @(negedge clk);
      s = snap(inst);
      if (s[1] === 1'b1) begin
        qs = (inst == 0) ? q8.size() : q7.size();
        chk($sformatf("i%0d_frame_expected", inst), (qs != 0), 1);
        if (qs == 0) begin
          for (int c = 0; c < 200 && snap(inst)[1] === 1'b1; c++) @(negedge clk);
        end else begin
          f = (inst == 0) ? q8.pop_front() : q7.pop_front();
          aborted = 0;
          for (int k = 0; k < f.len && !aborted; k++) begin
            want  = {1'b0, f.bits[k], 3'b110};
            act   = want;
            first = 1;
            for (int j = 0; j < DIV && !aborted; j++) begin
              if (k > 0 || j > 0) begin
                @(negedge clk);
                s = snap(inst);
              end
              if (rst) aborted = 1;
              else if (first && s !== want) begin
                act = s;
                first = 0;
              end
            end
            chk($sformatf("i%0d_bit%0d", inst, k), act, want);
          end
          chk($sformatf("i%0d_abort_seen", inst), aborted, f.abort);
          @(negedge clk);
          s = snap(inst);
          if (aborted) chk($sformatf("i%0d_after_abort", inst), s, 5'b01001);
          else         chk($sformatf("i%0d_frame_done", inst), s, 5'b11001);
        end
      end else if (s[4] === 1'b1) begin
        chk($sformatf("i%0d_spurious_done", inst), s[4], 0);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic set_valid(input int inst, input logic v);
    if (inst == 0) if8.tx_valid = v;
    else           if7.tx_valid = v;
  endtask

  // Present a word and wait (bounded) for the accept edge; returns 1 time unit after it
  task automatic send(input int inst, input logic [8:0] d, input logic [1:0] p, input bit s2,
                      input bit pen, input logic pb, input bit ab);
    frame_t f;
    bit got;
    f = make_frame(d, (inst == 0) ? 8 : 7, pen, pb, s2, ab);
    if (inst == 0) begin
      if8.tx_data = d[7:0]; if8.cfg_parity = p; if8.cfg_stop2 = s2; if8.tx_valid = 1'b1;
    end else begin
      if7.tx_data = d[6:0]; if7.cfg_parity = p; if7.cfg_stop2 = s2; if7.tx_valid = 1'b1;
    end
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (snap(inst)[0] === 1'b1) begin
        if (inst == 0) q8.push_back(f);
        else           q7.push_back(f);
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("i%0d_accept_%0h", inst, d), got, 1);
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (q8.size() == 0 && q7.size() == 0 && busy8 === 1'b0 && busy7 === 1'b0) break;
    end
    chk("drain", q8.size() + q7.size() + int'(busy8) + int'(busy7), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if8.tx_data = 8'h00; if8.tx_valid = 1'b0; if8.cfg_parity = 2'b00; if8.cfg_stop2 = 1'b0;
    if7.tx_data = 7'h00; if7.tx_valid = 1'b0; if7.cfg_parity = 2'b00; if7.cfg_stop2 = 1'b0;

    // valid during reset must not be accepted
    repeat (2) @(posedge clk);
    #1;
    if8.tx_data = 8'hE7; if8.tx_valid = 1'b1;
    @(negedge clk);
    chk("reset_state_i0", snap(0), 5'b01000);
    chk("reset_state_i1", snap(1), 5'b01000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if8.tx_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset_i0", snap(0), 5'b01001);
    chk("ready_after_reset_i1", snap(1), 5'b01001);
    @(posedge clk);
    #1;

    // 8N1 0x55, then even parity 0x07 (three ones -> parity 1)
    send(0, 9'h055, 2'b00, 0, 0, 1'b0, 0); set_valid(0, 1'b0);
    send(0, 9'h007, 2'b10, 0, 1, 1'b1, 0); set_valid(0, 1'b0);

    // back-to-back with valid held: 0xA5 odd (4 ones -> 1), 0x3C even 2 stops (4 ones -> 0)
    send(0, 9'h0A5, 2'b01, 0, 1, 1'b1, 0);
    send(0, 9'h03C, 2'b10, 1, 1, 1'b0, 0); set_valid(0, 1'b0);
    wait_idle();

    // reset pulse in the middle of data bit 3
    send(0, 9'h096, 2'b00, 0, 0, 1'b0, 1); set_valid(0, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clean frame after abort; parity code 11 means none
    send(0, 9'h0C3, 2'b11, 0, 0, 1'b0, 0); set_valid(0, 1'b0);

    // mid-frame input changes and valid pulses while busy: 0x81 odd (2 ones -> 1)
    send(0, 9'h081, 2'b01, 0, 1, 1'b1, 0); set_valid(0, 1'b0);
    if8.tx_data = 8'hFF; if8.cfg_parity = 2'b10; if8.cfg_stop2 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if8.tx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if8.tx_valid = 1'b0;
    wait_idle();

    // 7-bit instance: 0x00 odd with 2 stops (parity 1), 0x35 even (4 ones -> 0)
    send(1, 9'h000, 2'b01, 1, 1, 1'b1, 0); set_valid(1, 1'b0);
    send(1, 9'h035, 2'b10, 0, 1, 1'b0, 0); set_valid(1, 1'b0);
    wait_idle();

    repeat (30) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
